// File: rtl/pif_decode_arbiter.sv
// pif_decode_arbiter: round-robin arbiter that shares one posit_to_pif decoder
// among NREQ valid/ready requesters and queues {pif, requester id} in a small FIFO.
//
// PIF word layout: {sign, te, mant}
//   te   : signed total exponent, regime * 2^ES + exponent field
//   mant : hidden 1 followed by the fraction bits, left aligned
//   zero : all bits 0
//   NaR  : sign = 1, te = 0, mant = 0 (a real value always has the hidden 1 set)
module pif_decode_arbiter #(
    parameter  int N         = 16,
    parameter  int ES        = 1,
    parameter  int NREQ      = 4,
    parameter  int DEPTH     = 2,
    localparam int TE_SIZE   = ES + $clog2(N) + 1,
    localparam int MANT_SIZE = N - 2,
    localparam int PIF_SIZE  = 1 + TE_SIZE + MANT_SIZE,
    localparam int ID_W      = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     in_valid,
    input  logic [NREQ*N-1:0]   in_posit,
    output logic [NREQ-1:0]     in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PIF_SIZE-1:0] out_pif,
    output logic [ID_W-1:0]     out_id,
    output logic                busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RUN_W = $clog2(N) + 1;

    logic [PIF_SIZE-1:0] pif_mem [DEPTH];
    logic [ID_W-1:0]     id_mem  [DEPTH];
    logic [PTR_W-1:0]    wptr;
    logic [PTR_W-1:0]    rptr;
    logic [CNT_W-1:0]    count;
    logic [ID_W-1:0]     rr;

    logic [ID_W-1:0]     grant;
    logic [ID_W-1:0]     cand;
    logic                any_valid;
    logic                can_push;
    logic                push;
    logic                pop;
    int                  scan_idx;

    logic [N-1:0]        sel_posit;
    logic                sgn;
    logic [N-1:0]        mag;
    logic [N-2:0]        body;
    logic [N-2:0]        rem;
    logic [N-2:0]        exp_sh;
    logic [N-2:0]        frac_sh;
    logic [RUN_W-1:0]    run;
    logic                run_done;
    logic [TE_SIZE-1:0]  k_mag;
    logic signed [TE_SIZE-1:0] k;
    logic signed [TE_SIZE-1:0] te;
    logic [MANT_SIZE-1:0] mant;
    logic [PIF_SIZE-1:0] dec_pif;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_pif   = pif_mem[rptr];
    assign out_id    = id_mem[rptr];
    assign busy      = (count != '0) | (|in_valid);

    // Round-robin scan from rr; iterating downwards lets the nearest candidate win.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        scan_idx  = 0;
        cand      = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            scan_idx = int'(rr) + off;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            cand = ID_W'(scan_idx);
            if (in_valid[cand]) begin
                grant     = cand;
                any_valid = 1'b1;
            end
        end
    end

    // A full FIFO can still accept when the head leaves in the same cycle.
    always_comb begin
        can_push = (count < CNT_W'(DEPTH)) ||
                   ((count == CNT_W'(DEPTH)) && out_ready && out_valid);
        push     = any_valid & can_push & rst_n;
        in_ready = '0;
        if (push) in_ready[grant] = 1'b1;
    end

    // Select the granted requester's posit.
    always_comb begin
        sel_posit = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == grant) sel_posit = in_posit[i*N +: N];
        end
    end

    // posit_to_pif: decode the magnitude, count the regime run, then peel off exponent and fraction.
    always_comb begin
        sgn      = sel_posit[N-1];
        mag      = sgn ? -sel_posit : sel_posit;
        body     = mag[N-2:0];
        run      = '0;
        run_done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!run_done && (body[i] == body[N-2])) run = run + 1'b1;
            else run_done = 1'b1;
        end
        k_mag   = TE_SIZE'(run);
        k       = body[N-2] ? $signed(k_mag - 1'b1) : $signed(-k_mag);
        rem     = body << (run + 1'b1);
        exp_sh  = rem >> (N - 1 - ES);
        te      = (k <<< ES) + $signed(TE_SIZE'(exp_sh));
        frac_sh = rem << ES;
        mant    = {1'b1, frac_sh[N-2 -: MANT_SIZE-1]};
        if (sel_posit == '0)
            dec_pif = '0;
        else if (sel_posit == {1'b1, {(N-1){1'b0}}})
            dec_pif = {1'b1, {(PIF_SIZE-1){1'b0}}};
        else
            dec_pif = {sgn, te, mant};
    end

    // FIFO storage, pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pif_mem[i] <= '0;
                id_mem[i]  <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rr    <= '0;
        end else begin
            if (push) begin
                pif_mem[wptr] <= dec_pif;
                id_mem[wptr]  <= grant;
                wptr          <= wptr + 1'b1;
                rr            <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pif_decode_arbiter.sv
// Testbench for pif_decode_arbiter: directed scenarios with a scoreboard that
// queues reference-decoded results at acceptance and compares them at pop.
module tb_pif_decode_arbiter;

    localparam int N     = 16;
    localparam int ES    = 1;
    localparam int NREQ  = 4;
    localparam int DEPTH = 2;
    localparam int PIF   = 21;
    localparam int ID_W  = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [PIF-1:0]  pif;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   in_valid;
    logic [NREQ*N-1:0] in_posit;
    logic [NREQ-1:0]   in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [PIF-1:0]    out_pif;
    logic [ID_W-1:0]   out_id;
    logic              busy;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t head_exp;
    logic [PIF-1:0] held_pif;

    always #5 clk = ~clk;

    pif_decode_arbiter #(.N(N), .ES(ES), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_posit(in_posit),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_pif(out_pif), .out_id(out_id), .busy(busy)
    );

    // Reference decoder: walks the posit bit by bit.
    function automatic logic [PIF-1:0] ref_decode(input logic [N-1:0] p);
        logic        s;
        logic [N-1:0] a;
        logic        r;
        int          i, run, k, e, te_i;
        logic [13:0] m;
        logic [5:0]  te6;
        if (p == 16'h0000) return '0;
        if (p == 16'h8000) return {1'b1, 20'b0};
        s = p[15];
        a = s ? (~p + 16'd1) : p;
        r = a[14];
        run = 0;
        i = 14;
        while (i >= 0 && a[i] == r) begin
            run++;
            i--;
        end
        k = r ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < ES; j++) begin
            e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
            i--;
        end
        m = 14'd1;
        for (int j = 0; j < 13; j++) begin
            m = {m[12:0], (i >= 0) ? a[i] : 1'b0};
            i--;
        end
        te_i = k * (1 << ES) + e;
        te6  = te_i[5:0];
        return {s, te6, m};
    endfunction

    // Scoreboard: pop/compare the head, then record this cycle's acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(in_ready) > 1) begin
                errors++;
                $display("FAIL in_ready_onehot: got %b, required one-hot or zero", in_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got id=%0d pif=%h, required nothing queued", out_id, out_pif);
                end else begin
                    head_exp = sb.pop_front();
                    if ({out_id, out_pif} !== head_exp) begin
                        errors++;
                        $display("FAIL sb_head: got id=%0d pif=%h, required id=%0d pif=%h",
                                 out_id, out_pif, head_exp.id, head_exp.pif);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (in_valid[i] && in_ready[i])
                    sb.push_back({ID_W'(i), ref_decode(in_posit[i*N +: N])});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_posit(input int i, input logic [N-1:0] v);
        in_posit[i*N +: N] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = '1;
        out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_posit(i, N'($urandom));
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got in_ready=%b out_valid=%b, required 0000/0", in_ready, out_valid);
            end
        end
        checks++;
        if (out_pif !== '0 || out_id !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: got pif=%h id=%0d busy=%b, required 0/0/1", out_pif, out_id, busy);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: got %b, required 0001", in_ready);
        end
        tick();
        in_valid = '0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_out: got valid=%b id=%0d, required 1/0", out_valid, out_id);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain: got valid=%b busy=%b, required 0/0", out_valid, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_posit(2, 16'h4000);
        in_valid = 4'b0100;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b, required 0100", in_ready);
        end
        tick();
        in_valid = '0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 || out_pif !== ref_decode(16'h4000)) begin
            errors++;
            $display("FAIL single_out: got valid=%b id=%0d pif=%h, required 1/2/%h",
                     out_valid, out_id, out_pif, ref_decode(16'h4000));
        end
        checks++;
        if (out_pif !== 21'h002000) begin
            errors++;
            $display("FAIL single_one_const: got %h, required 002000", out_pif);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        in_valid = '1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NREQ; i++) set_posit(i, N'($urandom));
            if (c == 1) set_posit(1, 16'h0000);
            if (c == 2) set_posit(2, 16'h8000);
            if (c == 3) set_posit(3, 16'hC000);
            if (c == 4) set_posit(0, 16'h7FFF);
            if (c == 5) set_posit(1, 16'h0001);
            #1;
            checks++;
            if (in_ready !== 4'(1 << (c % NREQ))) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b, required %b", c, in_ready, 4'(1 << (c % NREQ)));
            end
            if (c > 0) begin
                checks++;
                if (out_id !== 2'((c - 1) % NREQ) || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_out_id[%0d]: got id=%0d valid=%b, required %0d/1",
                             c, out_id, out_valid, (c - 1) % NREQ);
                end
            end
            tick();
        end
        in_valid = '0;
        #1;
        checks++;
        if (out_id !== 2'd3) begin
            errors++;
            $display("FAIL rr_last_id: got %0d, required 3", out_id);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_posit(i, N'($urandom));
        in_valid = 4'b1010;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_first: got %b, required 0010", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 4'b1000 || out_id !== 2'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: got ready=%b id=%0d valid=%b, required 1000/1/1", in_ready, out_id, out_valid);
        end
        tick();
        checks++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_id !== 2'd1) begin
            errors++;
            $display("FAIL bp_full: got ready=%b valid=%b id=%0d, required 0000/1/1", in_ready, out_valid, out_id);
        end
        held_pif = out_pif;
        tick();
        checks++;
        if (out_pif !== held_pif || out_id !== 2'd1 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold: got pif=%h id=%0d ready=%b, required %h/1/0000", out_pif, out_id, in_ready, held_pif);
        end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL fp_accept: got %b, required 0010", in_ready);
        end
        tick();
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd3 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL fp_still_full: got valid=%b id=%0d ready=%b, required 1/3/0000", out_valid, out_id, in_ready);
        end
        in_valid = '0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd1) begin
            errors++;
            $display("FAIL fp_order: got valid=%b id=%0d, required 1/1", out_valid, out_id);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fp_drain: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_posit(i, N'($urandom));
        in_valid = 4'b0001;
        tick();
        in_valid = 4'b0010;
        tick();
        in_valid = '0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mr_queued: got valid=%b busy=%b, required 1/1", out_valid, busy);
        end
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mr_async: got valid=%b busy=%b ready=%b, required 0/0/0000", out_valid, busy, in_ready);
        end
        rst_n = 1'b1;
        in_valid = '1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mr_after: got ready=%b valid=%b, required 0001/0", in_ready, out_valid);
        end
        tick();
        in_valid = '0;
        tick();
        tick();
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mr_final: got queued=%0d valid=%b, required 0/0", sb.size(), out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = '0;
        in_posit = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_full_pop();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pif_decode_arbiter.md
Name: pif_decode_arbiter

Overview:
- Shares one posit_to_pif decoder among NREQ independent requesters, each using a valid/ready handshake.
- A round-robin arbiter picks one requester per cycle and decodes its posit.
- The decoded PIF word and the requester index are pushed into a small output FIFO.
- Sits between the PPU operand-fetch ports and the PIF-domain arithmetic core.

Parameters:
- N, 16, posit width in bits.
- ES, 1, posit exponent-field size.
- NREQ, 4, number of requesters (2..8).
- DEPTH, 2, output FIFO entries (power of two, at least 2).
- Derived, not overridable: TE_SIZE = ES + $clog2(N) + 1.
- Derived: MANT_SIZE = N - 2.
- Derived: PIF_SIZE = 1 + TE_SIZE + MANT_SIZE.
- Derived: ID_W = $clog2(NREQ).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NREQ  per-requester request valid.
- in_posit  input  NREQ*N  packed posits; requester i occupies bits [i*N +: N].
- in_ready  output  NREQ  one-hot-or-zero; a transfer occurs on in_valid[i] & in_ready[i].
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head.
- out_pif  output  PIF_SIZE  decoded {sign, te, mant} at the FIFO head.
- out_id  output  ID_W  requester index of the head entry.
- busy  output  1  FIFO non-empty or any in_valid asserted.

Behaviour:
- Reset, asynchronous, on rst_n low:
  - FIFO empty; read/write pointers and count = 0.
  - Round-robin pointer rr = 0.
  - out_valid = 0, out_pif = 0, out_id = 0.
  - in_ready = 0.
  - Asserting reset mid-operation discards all FIFO contents; nothing is replayed.
- Arbitration (combinational):
  - The grant is the first i with in_valid[i]=1, scanning from rr upward and wrapping modulo NREQ.
  - in_ready[grant] = 1 only when can_push is 1; every other in_ready bit is 0.
  - can_push = (count < DEPTH) OR (count == DEPTH AND out_ready AND out_valid), i.e. a simultaneous pop frees a slot in the same cycle.
  - in_ready may depend on in_valid; in_valid must not depend on in_ready.
- Accept (push):
  - posit_to_pif(in_posit[grant]) is written with id = grant into FIFO[wptr].
  - wptr increments modulo DEPTH.
  - rr becomes (grant + 1) mod NREQ.
  - With no accept, rr holds.
- Pop: on out_valid & out_ready, rptr increments modulo DEPTH.
- Count:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Latency:
  - A posit accepted in cycle t is visible at out_pif/out_id in cycle t+1 if the FIFO was empty.
  - Otherwise it appears behind the older entries.
- Outputs:
  - out_valid = (count != 0).
  - out_pif and out_id are driven from FIFO[rptr].
  - The head is held stable while out_valid & !out_ready.
- Ordering: output order equals acceptance order.
- Fairness: with all requesters continuously valid and the FIFO never blocking, grants cycle 0,1,...,NREQ-1,0,...
- Each requester may wait at most NREQ-1 grants to others before it is granted.
- Special values: NaR and zero pass through the decoder unchanged; the arbiter does not inspect them.
- Throughput: one accept per cycle sustained while out_ready = 1.
- busy is purely combinational from count and in_valid.

Test Plan:
- Reset: rst_n low for 3 cycles with all in_valid = 1 -> in_ready = 0, out_valid = 0; after release, the first grant goes to requester 0.
- Single requester: N=16, ES=1, requester 2 sends 16'h4000 with out_ready = 1 -> next cycle out_valid = 1, out_id = 2, out_pif equals posit_to_pif(16'h4000) from the reference model.
- Round robin: all 4 requesters valid continuously, out_ready = 1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3.
- Backpressure: out_ready = 0 with requesters 1 and 3 valid -> exactly 2 accepts (ids 1 then 3), then in_ready = 0 and the head is held stable.
- Full FIFO plus pop: assert out_ready for one cycle while the FIFO is full -> the same cycle pops one entry and accepts one, and count stays at 2.
- Reset mid-stream: drop rst_n asynchronously with 2 entries queued -> out_valid falls immediately without a clock edge; after release, rr = 0 and the FIFO is empty.
